// File: rtl/rom_sequenciador.sv
// -----------------------------------------------------------------------------
// rom_sequenciador
// Sequencer for a small combinational program ROM. It walks the ROM from a
// programmable start address and hands each word to one consumer over a
// valid/ready handshake. A zero word (when STOP_ON_ZERO=1) or the last address
// ends the program; in cyclic mode both wrap back to the start address instead.
//
// Ports
//   clock        system clock, rising edge
//   resetn       asynchronous active-low reset
//   inicio       start request (only honoured while idle)
//   end_inicial  start address, latched with inicio
//   ciclico      cyclic playback, latched with inicio
//   parar        abort request, level-sampled while busy
//   endereco     registered ROM address
//   dado         ROM word, combinational from endereco
//   saida        registered word offered to the consumer
//   valido       saida holds a valid word
//   pronto       consumer accepts the word
//   ocupado      high whenever the sequencer is not idle
//   fim          one-cycle pulse on completion or abort
//   contagem     words transferred since the last accepted inicio
// -----------------------------------------------------------------------------
module rom_sequenciador #(
   parameter int   AW           = 5,
   parameter int   DW           = 8,
   parameter logic STOP_ON_ZERO = 1'b1
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          inicio,
   input  logic [AW-1:0] end_inicial,
   input  logic          ciclico,
   input  logic          parar,
   output logic [AW-1:0] endereco,
   input  logic [DW-1:0] dado,
   output logic [DW-1:0] saida,
   output logic          valido,
   input  logic          pronto,
   output logic          ocupado,
   output logic          fim,
   output logic [AW:0]   contagem
);

   localparam logic [1:0] REPOUSO  = 2'd0;
   localparam logic [1:0] LER      = 2'd1;
   localparam logic [1:0] ENTREGAR = 2'd2;
   localparam logic [1:0] FIM      = 2'd3;

   localparam logic [AW-1:0] PTR_LAST = '1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

   logic [1:0]    state_q,    state_d;
   logic [AW-1:0] ptr_q,      ptr_d;
   logic [AW-1:0] base_q,     base_d;
   logic          modo_q,     modo_d;
   logic [DW-1:0] saida_q,    saida_d;
   logic          valido_q,   valido_d;
   logic [AW:0]   contagem_q, contagem_d;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      base_d     = base_q;
      modo_d     = modo_q;
      saida_d    = saida_q;
      valido_d   = valido_q;
      contagem_d = contagem_q;

      case (state_q)
         REPOUSO: begin
            if (inicio) begin
               ptr_d      = end_inicial;
               base_d     = end_inicial;
               modo_d     = ciclico;
               contagem_d = '0;
               state_d    = LER;
            end
         end

         LER: begin
            if (parar) begin
               state_d = FIM;
            end else if (STOP_ON_ZERO && (dado == '0)) begin
               // A zero at the start address always terminates, so a cyclic
               // program with no words cannot loop forever.
               if (modo_q && (ptr_q != base_q)) begin
                  ptr_d = base_q;
               end else begin
                  state_d = FIM;
               end
            end else begin
               saida_d  = dado;
               valido_d = 1'b1;
               state_d  = ENTREGAR;
            end
         end

         ENTREGAR: begin
            if (pronto) begin
               // The handshake completes even when parar arrives with it.
               contagem_d = contagem_q + CNT_ONE;
               valido_d   = 1'b0;
               if (parar) begin
                  state_d = FIM;
               end else if (ptr_q == PTR_LAST) begin
                  if (modo_q) begin
                     ptr_d   = base_q;
                     state_d = LER;
                  end else begin
                     state_d = FIM;
                  end
               end else begin
                  ptr_d   = ptr_q + PTR_ONE;
                  state_d = LER;
               end
            end else if (parar) begin
               valido_d = 1'b0;
               state_d  = FIM;
            end
         end

         FIM: begin
            valido_d = 1'b0;
            state_d  = REPOUSO;
         end

         default: begin
            valido_d = 1'b0;
            state_d  = REPOUSO;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= REPOUSO;
         ptr_q      <= '0;
         base_q     <= '0;
         modo_q     <= 1'b0;
         saida_q    <= '0;
         valido_q   <= 1'b0;
         contagem_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         base_q     <= base_d;
         modo_q     <= modo_d;
         saida_q    <= saida_d;
         valido_q   <= valido_d;
         contagem_q <= contagem_d;
      end
   end

   assign endereco = ptr_q;
   assign saida    = saida_q;
   assign valido   = valido_q;
   assign contagem = contagem_q;
   assign ocupado  = (state_q != REPOUSO);
   assign fim      = (state_q == FIM);

endmodule

// File: tb/tb_rom_sequenciador.sv
// -----------------------------------------------------------------------------
// tb_rom_sequenciador
// Scoreboard bench for rom_sequenciador. A ROM image lives in the bench; for
// each program run the expected word list is derived by walking the image
// directly and pushed into a queue, and an independent monitor pops one entry
// for every handshake the DUT completes.
// -----------------------------------------------------------------------------
module tb_rom_sequenciador;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       inicio = 1'b0;
   logic [4:0] end_inicial = '0;
   logic       ciclico = 1'b0;
   logic       parar = 1'b0;
   logic [4:0] endereco;
   logic [7:0] dado;
   logic [7:0] saida;
   logic       valido;
   logic       pronto = 1'b0;
   logic       ocupado;
   logic       fim;
   logic [5:0] contagem;

   logic [7:0] rom [32];
   assign dado = rom[endereco];

   logic [7:0] exp_q[$];
   logic [7:0] model_q[$];
   bit         model_end31;

   int total = 0;
   int bad   = 0;
   int fim_seen = 0;

   rom_sequenciador #(.AW(5), .DW(8), .STOP_ON_ZERO(1'b1)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .inicio      (inicio),
      .end_inicial (end_inicial),
      .ciclico     (ciclico),
      .parar       (parar),
      .endereco    (endereco),
      .dado        (dado),
      .saida       (saida),
      .valido      (valido),
      .pronto      (pronto),
      .ocupado     (ocupado),
      .fim         (fim),
      .contagem    (contagem)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference walk of the ROM image, capped at 'cap' delivered words.
   task automatic build_model(input int st, input bit cyc, input int cap);
      int p;
      p = st;
      model_q.delete();
      model_end31 = 1'b0;
      while (model_q.size() < cap) begin
         if (rom[p] == 8'h00) begin
            if (cyc && p != st) p = st;
            else break;
         end else begin
            model_q.push_back(rom[p]);
            if (p == 31) begin
               if (cyc) p = st;
               else begin
                  model_end31 = 1'b1;
                  break;
               end
            end else begin
               p++;
            end
         end
      end
   endtask

   // Monitor: samples shortly after the falling edge, away from input drive.
   logic       prev_v = 1'b0, prev_p = 1'b0, prev_par = 1'b0;
   logic [7:0] prev_s = '0;
   initial begin
      forever begin
         @(negedge clock);
         #2;
         if (!resetn) begin
            prev_v = 1'b0;
            continue;
         end
         if (fim) fim_seen++;
         if (prev_v && !prev_p && !prev_par) begin
            check("hold_stable", {23'd0, valido, saida}, {23'd0, 1'b1, prev_s});
         end
         if (valido && pronto) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", {24'd0, saida}, 32'hFFFF_FFFF);
            end else begin
               check("word", {24'd0, saida}, {24'd0, exp_q.pop_front()});
            end
         end
         prev_v = valido; prev_p = pronto; prev_par = parar; prev_s = saida;
      end
   end

   // One program run. k_stop>0: parar together with handshake number k_stop.
   // d_drop>=0: parar with pronto=0 while word number d_drop is offered.
   task automatic run(input int st, input bit cyc, input int k_stop, input int d_drop,
                      input int p_pct);
      int  cap, n, edges, hs, first_v, fim_edges, fim0;
      bit  got_fim, hsn, empty_prog;
      cap = 64;
      if (k_stop > 0 && k_stop < cap) cap = k_stop;
      if (d_drop >= 0 && d_drop < cap) cap = d_drop;
      build_model(st, cyc, cap);
      n = model_q.size();
      foreach (model_q[i]) exp_q.push_back(model_q[i]);
      empty_prog = (rom[st] == 8'h00);
      fim0 = fim_seen;

      @(negedge clock);
      inicio = 1'b1; end_inicial = 5'(st); ciclico = cyc; parar = 1'b0;
      @(posedge clock);
      edges = 1; hs = 0; first_v = 0; fim_edges = 0; got_fim = 1'b0;
      @(negedge clock);
      inicio = 1'b0; end_inicial = 5'($urandom); ciclico = 1'($urandom);
      while (!got_fim && edges < 2000) begin
         if (fim) begin
            got_fim = 1'b1;
            fim_edges = edges;
         end else begin
            if (valido && first_v == 0) first_v = edges;
            pronto = ($urandom_range(0, 99) < p_pct);
            parar  = 1'b0;
            if (valido && k_stop > 0 && hs == k_stop - 1 && pronto) parar = 1'b1;
            if (valido && d_drop >= 0 && hs == d_drop) begin
               pronto = 1'b0;
               parar  = 1'b1;
            end
            inicio = ($urandom_range(0, 7) == 0);
            hsn = valido && pronto;
            @(posedge clock);
            edges++;
            if (hsn) hs++;
            @(negedge clock);
         end
      end
      if (!got_fim) begin
         check("fim_timeout", 32'(edges), 32'd0);
         exp_q.delete();
      end
      // inicio offered during FIM must be ignored.
      parar = 1'b0;
      inicio = 1'b1;
      @(posedge clock);
      @(negedge clock);
      inicio = 1'b0;
      pronto = 1'b0;
      #3;
      check("idle_ocupado", {31'd0, ocupado}, 32'd0);
      check("idle_valido", {31'd0, valido}, 32'd0);
      check("contagem", {26'd0, contagem}, 32'(n));
      check("fim_pulses", 32'(fim_seen - fim0), 32'd1);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      if (empty_prog) check("empty_fim_latency", 32'(fim_edges), 32'd2);
      else            check("first_valid_latency", 32'(first_v), 32'd2);
      if (p_pct == 100 && !cyc && k_stop == 0 && d_drop < 0)
         check("throughput", 32'(fim_edges), model_end31 ? 32'(2*n+1) : 32'(2*n+2));
      exp_q.delete();
   endtask

   task automatic reset_mid_run();
      int fim0, w;
      @(negedge clock);
      inicio = 1'b1; end_inicial = 5'd0; ciclico = 1'b0; pronto = 1'b0; parar = 1'b0;
      @(posedge clock);
      @(negedge clock);
      inicio = 1'b0;
      w = 0;
      while (!valido && w < 10) begin
         @(negedge clock);
         w++;
      end
      check("reset_run_valido", {31'd0, valido}, 32'd1);
      fim0 = fim_seen;
      #3 resetn = 1'b0;
      #1;
      check("rst_endereco", {27'd0, endereco}, 32'd0);
      check("rst_saida", {24'd0, saida}, 32'd0);
      check("rst_valido", {31'd0, valido}, 32'd0);
      check("rst_ocupado", {31'd0, ocupado}, 32'd0);
      check("rst_fim", {31'd0, fim}, 32'd0);
      check("rst_contagem", {26'd0, contagem}, 32'd0);
      repeat (3) @(negedge clock);
      #3 resetn = 1'b1;
      repeat (4) @(negedge clock);
      #3;
      check("post_reset_idle", {31'd0, ocupado}, 32'd0);
      check("post_reset_no_fim", 32'(fim_seen - fim0), 32'd0);
   endtask

   initial begin
      logic [7:0] img [10];
      int st, k, d, pct;
      bit cyc;
      img = '{8'h13, 8'h15, 8'h16, 8'h04, 8'h48, 8'h04, 8'h02, 8'h0C, 8'h37, 8'hA5};
      for (int i = 0; i < 32; i++) rom[i] = (i < 10) ? img[i] : 8'h00;

      #3;
      check("reset_endereco", {27'd0, endereco}, 32'd0);
      check("reset_saida", {24'd0, saida}, 32'd0);
      check("reset_valido", {31'd0, valido}, 32'd0);
      check("reset_ocupado", {31'd0, ocupado}, 32'd0);
      check("reset_fim", {31'd0, fim}, 32'd0);
      check("reset_contagem", {26'd0, contagem}, 32'd0);
      @(negedge clock);
      #3 resetn = 1'b1;

      run(0, 1'b0, 0, -1, 100);   // one-shot, full rate
      run(0, 1'b0, 0, -1, 25);    // backpressure
      run(8, 1'b1, 5, -1, 100);   // cyclic, stop on 5th handshake
      run(12, 1'b0, 0, -1, 100);  // empty, one-shot
      run(12, 1'b1, 3, -1, 100);  // empty, cyclic
      run(0, 1'b0, 0, 4, 100);    // drop word 48
      run(9, 1'b0, 0, -1, 100);   // restart at A5
      reset_mid_run();

      // Randomised ROM contents and run parameters.
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < 32; i++)
            rom[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
         st  = $urandom_range(0, 31);
         cyc = 1'($urandom);
         k   = cyc ? $urandom_range(1, 12) : 0;
         d   = ($urandom_range(0, 9) < 3) ? $urandom_range(0, 8) : -1;
         pct = ($urandom_range(0, 1) == 0) ? 100 : $urandom_range(20, 90);
         run(st, cyc, k, d, pct);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
